// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave pins plus the parallel RAM-side word/response handshake.
// The frame_err signal exists only when SPI_SLAVE_FRAME_ERR_EN is defined.
interface spi_slave_if;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic       frame_err;
  modport slave (input SS_n, MOSI, tx_data, tx_valid, output MISO, rx_data, rx_valid, frame_err);
  modport master (output SS_n, MOSI, tx_data, tx_valid, input MISO, rx_data, rx_valid, frame_err);
`else
  modport slave (input SS_n, MOSI, tx_data, tx_valid, output MISO, rx_data, rx_valid);
  modport master (output SS_n, MOSI, tx_data, tx_valid, input MISO, rx_data, rx_valid);
`endif
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI slave that assembles 10-bit RAM words and shifts 8-bit read data back on MISO.
// Optional frame_err abort strobe is enabled by defining SPI_SLAVE_FRAME_ERR_EN.
module spi_slave (
  input logic       clk,
  input logic       rst_n,
  spi_slave_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, CHK_CMD = 3'd1, WRITE = 3'd2, READ_ADD = 3'd3, READ_DATA = 3'd4} state_t;
  state_t     state;
  logic [3:0] bit_cnt;
  logic [3:0] tx_cnt;
  logic [8:0] shreg;
  logic [7:0] tx_sh;
  logic       done;
  logic       tx_busy;
  logic       tx_done;
  logic       rd_addr_seen;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       frame_ok;
  logic       tx_wait;
  assign bus.MISO     = miso;
  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;
  // a READ_DATA frame is only complete once its byte has been fully shifted out
  assign frame_ok = done && (state != READ_DATA || tx_done);
  // the response wait opens the cycle after the rx_valid strobe
  assign tx_wait  = state == READ_DATA && done && !rx_valid && !tx_busy && !tx_done;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err;
  assign bus.frame_err = frame_err;
`endif
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      tx_cnt       <= '0;
      shreg        <= '0;
      tx_sh        <= '0;
      done         <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      rd_addr_seen <= 1'b0;
      miso         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err    <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      if (state != IDLE && bus.SS_n) begin
        state   <= IDLE;
        bit_cnt <= '0;
        tx_cnt  <= '0;
        miso    <= 1'b0;
        done    <= 1'b0;
        tx_busy <= 1'b0;
        tx_done <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_err <= !frame_ok;
`endif
      end else begin
        case (state)
          IDLE:    if (!bus.SS_n) state <= CHK_CMD;
          CHK_CMD: state <= bus.MOSI ? (rd_addr_seen ? READ_DATA : READ_ADD) : WRITE;
          default: begin
            if (!done) begin
              shreg   <= {shreg[7:0], bus.MOSI};
              bit_cnt <= bit_cnt == 4'd9 ? 4'd0 : bit_cnt + 4'd1;
              if (bit_cnt == 4'd9) begin
                done     <= 1'b1;
                rx_valid <= 1'b1;
                rx_data  <= {shreg, bus.MOSI};
                rd_addr_seen <= state == READ_ADD ? 1'b1 : state == READ_DATA ? 1'b0 : rd_addr_seen;
              end
            end else if (tx_busy) begin
              miso    <= tx_cnt == 4'd8 ? 1'b0 : tx_sh[7];
              tx_sh   <= {tx_sh[6:0], 1'b0};
              tx_cnt  <= tx_cnt == 4'd8 ? 4'd0 : tx_cnt + 4'd1;
              tx_busy <= tx_cnt != 4'd8;
              tx_done <= tx_cnt == 4'd8;
            end else if (tx_wait && bus.tx_valid) begin
              miso    <= bus.tx_data[7];
              tx_sh   <= {bus.tx_data[6:0], 1'b0};
              tx_cnt  <= 4'd1;
              tx_busy <= 1'b1;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed self-checking bench for spi_slave (write, read-address, read-data, aborts, reset).
module tb_spi_slave;
  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total = 0;
  spi_slave_if bus ();
  spi_slave dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic start(input logic sel, input logic [2:0] st);
    bus.SS_n = 1'b0;
    tick();
    chk("chk_cmd_state", dut.state, 3'd1);
    bus.MOSI = sel;
    tick();
    chk("frame_state", dut.state, st);
  endtask

  task automatic shift(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) begin
      bus.MOSI = w[i];
      chk("no_early_valid", bus.rx_valid, 1'b0);
      tick();
    end
    chk("rx_valid_pulse", bus.rx_valid, 1'b1);
    chk("rx_data", bus.rx_data, w);
  endtask

  task automatic end_frame();
    bus.SS_n = 1'b1;
    tick();
    chk("idle_after_ss", dut.state, 3'd0);
    chk("miso_idle", bus.MISO, 1'b0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    chk("no_frame_err", bus.frame_err, 1'b0);
`endif
  endtask

  task automatic shift_out(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = ~b;
      chk("miso_bit", bus.MISO, b[i]);
      tick();
    end
    bus.tx_valid = 1'b0;
    chk("miso_after", bus.MISO, 1'b0);
    tick();
    chk("miso_stays_0", bus.MISO, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    tick();
    tick();
    rst_n = 1'b0;
    chk("rst_state", dut.state, 3'd0);
    chk("rst_rx_valid", bus.rx_valid, 1'b0);
    chk("rst_miso", bus.MISO, 1'b0);
    chk("rst_rx_data", bus.rx_data, 10'h000);
    chk("rst_rd_seen", dut.rd_addr_seen, 1'b0);
    // write address frame
    start(1'b0, 3'd2);
    shift(10'h0A5);
    chk("wr_rd_seen", dut.rd_addr_seen, 1'b0);
    bus.MOSI = 1'b1;
    tick();
    chk("rx_valid_one_cycle", bus.rx_valid, 1'b0);
    tick();
    tick();
    chk("rx_data_hold", bus.rx_data, 10'h0A5);
    chk("no_extra_valid", bus.rx_valid, 1'b0);
    end_frame();
    // read address then read data with immediate response
    start(1'b1, 3'd3);
    shift(10'h20F);
    chk("rd_seen_set", dut.rd_addr_seen, 1'b1);
    end_frame();
    start(1'b1, 3'd4);
    shift(10'h300);
    chk("rd_seen_clr", dut.rd_addr_seen, 1'b0);
    tick();
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'hC3;
    chk("miso_pre", bus.MISO, 1'b0);
    tick();
    shift_out(8'hC3);
    end_frame();
    // tx_valid before rx_valid ignored, response 3 cycles after rx_valid
    start(1'b1, 3'd3);
    shift(10'h123);
    end_frame();
    start(1'b1, 3'd4);
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'hFF;
    shift(10'h2AA);
    bus.tx_valid = 1'b0;
    chk("early_tx_ignored0", bus.MISO, 1'b0);
    tick();
    chk("early_tx_ignored1", bus.MISO, 1'b0);
    tick();
    chk("early_tx_ignored2", bus.MISO, 1'b0);
    tick();
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h5A;
    chk("early_tx_ignored3", bus.MISO, 1'b0);
    tick();
    shift_out(8'h5A);
    end_frame();
    // abort during shift-out
    start(1'b1, 3'd3);
    shift(10'h011);
    end_frame();
    start(1'b1, 3'd4);
    shift(10'h2AA);
    tick();
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'hFF;
    tick();
    bus.tx_valid = 1'b0;
    tick();
    tick();
    chk("shift_active", bus.MISO, 1'b1);
    bus.SS_n = 1'b1;
    tick();
    chk("abort_tx_state", dut.state, 3'd0);
    chk("abort_tx_miso", bus.MISO, 1'b0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    chk("abort_tx_err", bus.frame_err, 1'b1);
    tick();
    chk("abort_tx_err_clr", bus.frame_err, 1'b0);
`endif
    // abort a write after 5 bits
    start(1'b0, 3'd2);
    for (int i = 0; i < 5; i++) begin
      bus.MOSI = 1'b1;
      tick();
    end
    bus.SS_n = 1'b1;
    tick();
    chk("abort_wr_state", dut.state, 3'd0);
    chk("abort_wr_valid", bus.rx_valid, 1'b0);
    chk("abort_wr_hold", bus.rx_data, 10'h2AA);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    chk("abort_wr_err", bus.frame_err, 1'b1);
`endif
    tick();
    chk("abort_wr_valid2", bus.rx_valid, 1'b0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    chk("abort_wr_err_clr", bus.frame_err, 1'b0);
`endif
    // partial read-address frame leaves rd_addr_seen untouched
    start(1'b1, 3'd3);
    for (int i = 0; i < 5; i++) begin
      bus.MOSI = 1'b1;
      tick();
    end
    bus.SS_n = 1'b1;
    tick();
    chk("abort_ra_rd_seen", dut.rd_addr_seen, 1'b0);
    chk("abort_ra_valid", bus.rx_valid, 1'b0);
    // reset in the middle of a frame
    start(1'b1, 3'd3);
    shift(10'h155);
    bus.SS_n = 1'b1;
    tick();
    start(1'b0, 3'd2);
    for (int i = 0; i < 4; i++) begin
      bus.MOSI = i[0];
      tick();
    end
    rst_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    chk("midrst_state", dut.state, 3'd0);
    chk("midrst_valid", bus.rx_valid, 1'b0);
    chk("midrst_miso", bus.MISO, 1'b0);
    chk("midrst_rx_data", bus.rx_data, 10'h000);
    chk("midrst_rd_seen", dut.rd_addr_seen, 1'b0);
    bus.SS_n = 1'b1;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001: The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst_n (rst_n = 1 resets; the name is kept as in the codebase despite the polarity).
REQ-002: clk  input  1  system clock; all logic samples on the rising edge.
REQ-003: rst_n  input  1  synchronous active-high reset.
REQ-004: SS_n  input  1  SPI slave select, active-low; high aborts or ends the frame.
REQ-005: MOSI  input  1  serial data from the master, sampled once per clk.
REQ-006: MISO  output  1  serial read data to the master.
REQ-007: rx_data  output  10  parallel word to the RAM; [9:8] is the command (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data).
REQ-008: rx_valid  output  1  one-cycle strobe; rx_data is valid in the same cycle.
REQ-009: tx_data  input  8  read data returned by the RAM.
REQ-010: tx_valid  input  1  tx_data is valid in this cycle.

Function
REQ-011: The FSM SHALL have the states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-012: IDLE SHALL go to CHK_CMD on the cycle after SS_n is sampled low.
REQ-013: CHK_CMD SHALL sample one select bit from MOSI and go to one of:
- 0 -> WRITE
- 1 with rd_addr_seen = 0 -> READ_ADD
- 1 with rd_addr_seen = 1 -> READ_DATA
REQ-014: WRITE, READ_ADD and READ_DATA SHALL each shift in exactly 10 MOSI bits, MSB first, one per clk, using a 4-bit counter running 0..9.
REQ-015: On the cycle after the 10th bit is sampled, the block SHALL drive rx_data with the assembled word and pulse rx_valid for exactly one cycle.
REQ-016: No further bits SHALL be shifted in until SS_n goes high.
REQ-017: The internal flag rd_addr_seen SHALL be set when a READ_ADD frame completes and cleared when a READ_DATA frame completes; WRITE frames SHALL leave it unchanged.
REQ-018: After its rx_valid pulse, READ_DATA SHALL wait for tx_valid and capture tx_data in the first cycle tx_valid = 1.
REQ-019: If tx_valid is captured in cycle N, MISO SHALL carry tx_data[7] in cycle N+1 through tx_data[0] in cycle N+8, then return to 0.
REQ-020: tx_valid SHALL be ignored outside the READ_DATA wait phase and during shift-out.
REQ-021: SS_n sampled high in any non-IDLE state SHALL return the FSM to IDLE on the next cycle, with these effects:
- the bit and tx counters clear and MISO is forced to 0;
- a partial frame produces no rx_valid and does not change rd_addr_seen;
- an interrupted MISO shift-out is discarded.
REQ-022: rx_data SHALL hold its last value between strobes.
REQ-023: MISO SHALL be 0 whenever the block is not shifting out read data.

Reset
REQ-024: While rst_n = 1 at a clk edge, the following SHALL hold on the next cycle:
- state = IDLE;
- rx_data = 0, rx_valid = 0, MISO = 0;
- rd_addr_seen = 0 and all counters = 0.
REQ-025: Reset SHALL take priority over SS_n and tx_valid, including in the middle of a frame or a shift-out.

Configuration
REQ-026: When the macro SPI_SLAVE_FRAME_ERR_EN is defined, the block SHALL add an output port frame_err (1 bit, reset 0).
REQ-027: frame_err SHALL pulse for one cycle when SS_n rises before either of these completes:
- a 10-bit frame;
- a READ_DATA 8-bit shift-out.
REQ-028: When SPI_SLAVE_FRAME_ERR_EN is undefined, the frame_err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029: Reset: hold rst_n = 1 for 2 cycles during an active frame -> state IDLE, rx_valid = 0, MISO = 0, rx_data = 0.
REQ-030: Write address: SS_n low, select 0, bits 00_1010_0101 -> one rx_valid pulse with rx_data = 10'h0A5; rd_addr_seen unchanged.
REQ-031: Read address: SS_n low, select 1, bits 10_0000_1111 -> rx_data = 10'h20F and rx_valid pulse; rd_addr_seen = 1, so the next select-1 frame enters READ_DATA.
REQ-032: Read data: select 1, bits 11_0000_0000 -> rx_valid pulse; tx_valid pulse with tx_data = 8'hC3 -> MISO = 1,1,0,0,0,0,1,1 over the next 8 cycles, then 0; rd_addr_seen = 0.
REQ-033: Abort: SS_n raised after 5 WRITE bits -> no rx_valid and IDLE next cycle; with SPI_SLAVE_FRAME_ERR_EN defined, a one-cycle frame_err pulse.
REQ-034: Read data, tx_valid timing: tx_valid asserted before the rx_valid pulse is ignored; tx_valid asserted 3 cycles after rx_valid is captured and shifted out per REQ-019.
